// File: rtl/ctr_capture_if.sv
// Config-write and capture-FIFO read bus of the cog counter capture block.
// The master side configures the block and pops entries; the slave side is ctr_capture.
interface ctr_capture_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             cfg_wr;
    logic [31:0]      cfg_data;
    logic             rd;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             full;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    modport master (
        output cfg_wr,
        output cfg_data,
        output rd,
        input  rd_data,
        input  rd_valid,
        input  full,
        input  ovf,
        input  cnt
    );

    modport slave (
        input  cfg_wr,
        input  cfg_data,
        input  rd,
        output rd_data,
        output rd_valid,
        output full,
        output ovf,
        output cnt
    );
endinterface

// File: rtl/ctr_capture.sv
// Pin edge capture: synchronizes one selected pin, detects the configured edge and
// stores the absolute or delta phase value into a small FIFO with a sticky overflow flag.
module ctr_capture #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_cog,
    input  logic          res,
    input  logic          ena,
    input  logic [31:0]   pin_in,
    input  logic [32:0]   phs,
    ctr_capture_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);
    localparam logic [2:0]       SETTLE_INIT = 3'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_t;

    typedef struct packed {
        logic       delta;
        edge_mode_t mode;
        logic [4:0] pin;
    } cfg_t;

    cfg_t                   cfg;
    logic [SYNC_STAGES-1:0] s;
    logic                   hist;
    logic [31:0]            last;
    logic [2:0]             settle;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       cnt;
    logic                   ovf;
    logic [31:0]            mem [DEPTH];

    logic        local_rst;
    logic        sync_bit;
    logic        edge_hit;
    logic        edge_det;
    logic        push;
    logic        pop;
    logic        is_full;
    logic        do_write;
    logic        drop;
    logic [31:0] cap_value;

    wire unused_bits = &{1'b0, phs[32], bus.cfg_data[31:8]};

    assign local_rst = res | ~ena;
    assign sync_bit  = s[SYNC_STAGES-1];
    assign is_full   = (cnt == DEPTH_CNT);

    // Synchronizer and history keep shifting during the settle window so that
    // the chain is clean by the time edge detection re-enables.
    always_ff @(posedge clk_cog) begin
        if (local_rst) begin
            s    <= '0;
            hist <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1) begin
                s <= {s[SYNC_STAGES-2:0], pin_in[cfg.pin]};
            end else begin
                s <= pin_in[cfg.pin];
            end
            hist <= sync_bit;
        end
    end

    always_comb begin
        edge_hit = 1'b0;
        case (cfg.mode)
            MODE_RISE: edge_hit = sync_bit & ~hist;
            MODE_FALL: edge_hit = ~sync_bit & hist;
            MODE_BOTH: edge_hit = sync_bit ^ hist;
            default:   edge_hit = 1'b0;
        endcase
    end

    // A config write overrides any same-cycle edge or pop.
    assign edge_det  = edge_hit && (settle == 3'd0);
    assign push      = edge_det && !bus.cfg_wr;
    assign pop       = bus.rd && (cnt != '0) && !bus.cfg_wr;
    assign do_write  = push && (!is_full || pop);
    assign drop      = push && is_full && !pop;
    assign cap_value = cfg.delta ? (phs[31:0] - last) : phs[31:0];

    always_ff @(posedge clk_cog) begin
        if (local_rst) begin
            cfg    <= '0;
            last   <= '0;
            settle <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (bus.cfg_wr) begin
            cfg    <= cfg_t'(bus.cfg_data[7:0]);
            last   <= phs[31:0];
            settle <= SETTLE_INIT;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (settle != 3'd0) begin
                settle <= settle - 3'd1;
            end
            // last follows every detected edge, even one that gets dropped.
            if (edge_det) begin
                last <= phs[31:0];
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_write && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !do_write) begin
                cnt <= cnt - 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_cog) begin
        if (!local_rst && do_write) begin
            mem[wr_ptr] <= cap_value;
        end
    end

    assign bus.cnt      = cnt;
    assign bus.rd_valid = (cnt != '0);
    assign bus.full     = is_full;
    assign bus.ovf      = ovf;
    assign bus.rd_data  = (cnt != '0) ? mem[rd_ptr] : 32'd0;
endmodule

// File: tb/tb_ctr_capture.sv
// Directed bench for ctr_capture: stimulus pushes expected captures into a queue,
// a negedge monitor compares every accepted pop against it.
module tb_ctr_capture;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic        clk_cog = 1'b0;
    logic        res;
    logic        ena;
    logic [31:0] pin_in;
    logic [32:0] phs;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    ctr_capture_if #(.DEPTH(DEPTH)) bus ();

    ctr_capture #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_cog (clk_cog),
        .res     (res),
        .ena     (ena),
        .pin_in  (pin_in),
        .phs     (phs),
        .bus     (bus)
    );

    always #5 clk_cog = ~clk_cog;

    // Every pop the DUT will accept at the coming edge is checked against the queue head.
    always @(negedge clk_cog) begin
        if (bus.rd && bus.rd_valid && !res && ena && !bus.cfg_wr) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_pop: got 0x%0h expected no entry", bus.rd_data);
            end else begin
                logic [31:0] exp_val;
                exp_val = sb.pop_front();
                if (bus.rd_data !== exp_val) begin
                    errors++;
                    $display("[TB] FAIL sb_data: got 0x%0h expected 0x%0h", bus.rd_data, exp_val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_cog);
        #1;
    endtask

    task automatic check_val(input string name, input logic [32:0] act, input logic [32:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic check_output(input string tag, input logic exp_valid, input logic exp_full,
                                input logic exp_ovf, input int exp_cnt, input logic [31:0] exp_data);
        check_val({tag, "_valid"}, 33'(bus.rd_valid), 33'(exp_valid));
        check_val({tag, "_full"},  33'(bus.full),     33'(exp_full));
        check_val({tag, "_ovf"},   33'(bus.ovf),      33'(exp_ovf));
        check_val({tag, "_cnt"},   33'(bus.cnt),      33'(exp_cnt));
        check_val({tag, "_data"},  33'(bus.rd_data),  33'(exp_data));
    endtask

    task automatic configure(input logic [31:0] data, input logic [32:0] ph);
        bus.cfg_data = data;
        phs          = ph;
        bus.cfg_wr   = 1'b1;
        tick();
        bus.cfg_wr   = 1'b0;
        repeat (SYNC_STAGES + 1) tick();
    endtask

    // One high pulse on pin 3 with phs held at ph; optional pop on the rise capture edge.
    task automatic apply_stimulus(input logic [31:0] ph, input bit pop_at_capture,
                                  input logic [31:0] exp_val, input bit push_exp);
        pin_in[3]  = 1'b1;
        phs[31:0]  = ph;
        repeat (SYNC_STAGES) tick();
        bus.rd = pop_at_capture;
        tick();
        bus.rd = 1'b0;
        if (push_exp) sb.push_back(exp_val);
        pin_in[3] = 1'b0;
        repeat (SYNC_STAGES + 1) tick();
    endtask

    task automatic pop_n(input int n);
        bus.rd = 1'b1;
        repeat (n) tick();
        bus.rd = 1'b0;
    endtask

    initial begin
        res          = 1'b1;
        ena          = 1'b1;
        pin_in       = '0;
        phs          = '0;
        bus.cfg_wr   = 1'b0;
        bus.cfg_data = '0;
        bus.rd       = 1'b0;
        repeat (2) tick();
        res = 1'b0;
        check_output("reset", 1'b0, 1'b0, 1'b0, 0, 32'd0);

        // Absolute rise capture with exact synchronizer latency.
        configure(32'h23, 33'd0);
        pin_in[3] = 1'b1;
        phs       = 33'd100;
        repeat (SYNC_STAGES) tick();
        check_val("latency_early", 33'(bus.rd_valid), 33'd0);
        tick();
        sb.push_back(32'd100);
        check_output("abs_rise", 1'b1, 1'b0, 1'b0, 1, 32'd100);
        pop_n(1);
        check_val("abs_rise_pop_cnt", 33'(bus.cnt), 33'd0);
        pin_in[3] = 1'b0;
        repeat (SYNC_STAGES + 1) tick();

        // Delta captures relative to the config-write phase, then across the 2^32 wrap.
        configure(32'hA3, 33'd900);
        apply_stimulus(32'd1000, 1'b0, 32'd100, 1'b1);
        apply_stimulus(32'd1250, 1'b0, 32'd250, 1'b1);
        check_val("delta_cnt", 33'(bus.cnt), 33'd2);
        pop_n(2);
        configure(32'hA3, {1'b1, 32'hFFFF_FFF0});
        apply_stimulus(32'h0000_0010, 1'b0, 32'h20, 1'b1);
        check_output("delta_wrap", 1'b1, 1'b0, 1'b0, 1, 32'h20);
        pop_n(1);
        phs[32] = 1'b0;

        // Mode off never captures; fall and both modes capture on their edges.
        configure(32'h03, 33'd0);
        apply_stimulus(32'd7, 1'b0, 32'd0, 1'b0);
        check_val("mode_off_cnt", 33'(bus.cnt), 33'd0);
        configure(32'h43, 33'd0);
        apply_stimulus(32'd500, 1'b0, 32'd500, 1'b1);
        check_val("fall_cnt", 33'(bus.cnt), 33'd1);
        pop_n(1);
        configure(32'h63, 33'd0);
        apply_stimulus(32'd600, 1'b0, 32'd600, 1'b1);
        sb.push_back(32'd600);
        check_val("both_cnt", 33'(bus.cnt), 33'd2);
        pop_n(2);

        // Overflow, sticky ovf, empty pop, then simultaneous pop and push while full.
        configure(32'h23, 33'd0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(32'(11 * (i + 1)), 1'b0, 32'(11 * (i + 1)), i < 4);
        end
        check_output("overflow", 1'b1, 1'b1, 1'b1, 4, 32'd11);
        pop_n(4);
        check_output("drained", 1'b0, 1'b0, 1'b1, 0, 32'd0);
        pop_n(1);
        check_val("empty_pop_cnt", 33'(bus.cnt), 33'd0);
        configure(32'h23, 33'd0);
        check_val("cfg_clears_ovf", 33'(bus.ovf), 33'd0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(32'(61 + i), 1'b0, 32'(61 + i), 1'b1);
        end
        apply_stimulus(32'd65, 1'b1, 32'd65, 1'b1);
        check_output("push_pop_full", 1'b1, 1'b1, 1'b0, 4, 32'd62);
        pop_n(4);

        // Pin toggled inside the settle window is never captured; later toggles are.
        bus.cfg_data = 32'h23;
        bus.cfg_wr   = 1'b1;
        tick();
        bus.cfg_wr = 1'b0;
        pin_in[3]  = 1'b1;
        repeat (6) tick();
        check_val("settle_suppress_cnt", 33'(bus.cnt), 33'd0);
        pin_in[3] = 1'b0;
        repeat (SYNC_STAGES + 1) tick();
        apply_stimulus(32'd777, 1'b0, 32'd777, 1'b1);
        check_output("after_settle", 1'b1, 1'b0, 1'b0, 1, 32'd777);

        // Config write on the same edge as a capture and a pop discards everything.
        pin_in[3] = 1'b1;
        phs       = 33'd41;
        repeat (SYNC_STAGES) tick();
        bus.cfg_data = 32'h23;
        bus.cfg_wr   = 1'b1;
        bus.rd       = 1'b1;
        tick();
        bus.cfg_wr = 1'b0;
        bus.rd     = 1'b0;
        sb.delete();
        check_output("cfg_vs_edge", 1'b0, 1'b0, 1'b0, 0, 32'd0);
        pin_in[3] = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
        check_val("cfg_vs_edge_late_cnt", 33'(bus.cnt), 33'd0);

        // Reset beats a same-cycle cfg_wr and rd; capture resumes only after a new config.
        apply_stimulus(32'd10, 1'b0, 32'd10, 1'b1);
        apply_stimulus(32'd20, 1'b0, 32'd20, 1'b1);
        check_val("pre_reset_cnt", 33'(bus.cnt), 33'd2);
        res          = 1'b1;
        bus.cfg_data = 32'h23;
        bus.cfg_wr   = 1'b1;
        bus.rd       = 1'b1;
        tick();
        res        = 1'b0;
        bus.cfg_wr = 1'b0;
        bus.rd     = 1'b0;
        sb.delete();
        check_output("mid_reset", 1'b0, 1'b0, 1'b0, 0, 32'd0);
        apply_stimulus(32'd30, 1'b0, 32'd0, 1'b0);
        check_val("no_cfg_after_reset_cnt", 33'(bus.cnt), 33'd0);
        configure(32'h23, 33'd0);
        apply_stimulus(32'd333, 1'b0, 32'd333, 1'b1);
        check_output("post_reset_capture", 1'b1, 1'b0, 1'b0, 1, 32'd333);

        // Dropping ena acts exactly like reset.
        ena = 1'b0;
        tick();
        ena = 1'b1;
        sb.delete();
        check_output("ena_low", 1'b0, 1'b0, 1'b0, 0, 32'd0);
        apply_stimulus(32'd44, 1'b0, 32'd0, 1'b0);
        check_val("no_cfg_after_ena_cnt", 33'(bus.cnt), 33'd0);

        check_val("sb_leftover", 33'(sb.size()), 33'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
